led_pattern_gen: RTL

Round generator for the Precision Button Press game. It produces the 8-bit target pattern on `LEDS` that the downstream sequence checker latches and compares against the switches. It holds each pattern for a bounded display window and advances to a new pattern when the checker reports a match. A timeout ends the game. With the speed-up feature compiled in, the window shrinks as the level rises.

---
 rtl/game_pkg.sv | 20 ++
 rtl/lfsr8.sv | 23 ++
 rtl/led_pattern_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, constants and LFSR step for the pattern generator
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [2:0] MAX_LEVEL = 3'd7;

    // Galois form: shift right, fold the taps back in when a one falls off bit 0.
    function automatic logic [7:0] galois_step(input logic [7:0] cur, input logic [7:0] taps);
        logic [7:0] shifted;
        shifted = {1'b0, cur[7:1]};
        return cur[0] ? (shifted ^ taps) : shifted;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Galois LFSR that advances one step when step is high
module lfsr8 import game_pkg::*; #(
    parameter logic [7:0] SEED = 8'hA5,
    parameter logic [7:0] TAPS = LFSR_TAPS
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       step,
    output logic [7:0] q
);

    // An all-zero state would lock the register, so it is never used as a seed.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= SEED_EFF;
        end else if (step) begin
            q <= galois_step(q, TAPS);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - round FSM, display timer and level counter; LED_LEVEL_SPEEDUP_EN shrinks the window per level
module led_pattern_gen import game_pkg::*; #(
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       HIT,
    output logic [7:0] LEDS,
    output logic       ROUND_ACTIVE,
    output logic       MISS,
    output logic [2:0] LEVEL
);

    localparam int unsigned TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_W = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] ONE_W  = TW'(1);

    state_t        state;
    state_t        state_next;
    logic          start_q;
    logic          start_rise;
    logic          lfsr_step;
    logic [7:0]    lfsr_q;
    logic [TW-1:0] timer;
    logic [TW-1:0] window;

    assign start_rise = START & ~start_q;

    // The LFSR advances on the edge entering LOAD, so during LOAD its output
    // already holds the fresh pattern that LEDS captures on the way into SHOW.
    assign lfsr_step = ((state == IDLE) && start_rise) || ((state == SHOW) && HIT);

    lfsr8 #(
        .SEED (SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .CLK  (CLK),
        .RST  (RST),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

`ifdef LED_LEVEL_SPEEDUP_EN
    logic [TW-1:0] shifted;
    assign shifted = HOLD_W >> LEVEL;
    assign window  = (shifted == '0) ? ONE_W : shifted;
`else
    assign window = HOLD_W;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SHOW;
            end
            SHOW: begin
                if (HIT) begin
                    state_next = LOAD;
                end else if (timer == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ROUND_ACTIVE = (state == SHOW);

    always_ff @(posedge CLK) begin
        if (RST) begin
            start_q <= 1'b0;
            LEDS    <= '0;
            MISS    <= 1'b0;
            LEVEL   <= '0;
            timer   <= '0;
        end else begin
            start_q <= START;
            MISS    <= 1'b0;
            case (state)
                IDLE: begin
                    LEDS <= '0;
                end
                LOAD: begin
                    LEDS  <= lfsr_q;
                    timer <= window - ONE_W;
                end
                SHOW: begin
                    // A hit on the last window cycle still counts as a hit.
                    if (HIT) begin
                        if (LEVEL != MAX_LEVEL) begin
                            LEVEL <= LEVEL + 3'd1;
                        end
                    end else if (timer == '0) begin
                        MISS  <= 1'b1;
                        LEDS  <= '0;
                        LEVEL <= '0;
                    end else begin
                        timer <= timer - ONE_W;
                    end
                end
                default: begin
                    LEDS <= '0;
                end
            endcase
        end
    end

endmodule
